// File: rtl/script_sequencer.sv
`default_nettype none
// ============================================================================
// Module : script_sequencer
// Walks script memory, dispatches action/game words to their units and runs
// jump/wait words locally. Optional watchdog: define SEQ_WATCHDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================

module script_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 100000,
    parameter int WDOG_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              feedback_sig,
    output logic              act_start,
    output logic [7:0]        act_num,
    output logic [1:0]        act_func,
    input  logic              act_done,
    output logic              game_start,
    output logic [7:0]        game_num,
    input  logic              game_done,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    localparam int            TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    c_OP_END    = 3'd0;
    localparam logic [2:0]    c_OP_ACT    = 3'd1;
    localparam logic [2:0]    c_OP_JMP    = 3'd2;
    localparam logic [2:0]    c_OP_WAIT   = 3'd3;
    localparam logic [2:0]    c_OP_GAME   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_ACT, S_EXEC_GAME, S_WAIT, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              fetch_wait_q, fetch_wait_d;
    logic [7:0]        act_num_q, act_num_d;
    logic [1:0]        act_func_q, act_func_d;
    logic [7:0]        game_num_q, game_num_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [7:0]        left_q, left_d;

    logic [ADDR_W-1:0] w_num_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [1:0]        w_func;
    logic [2:0]        w_op;
    logic              w_unused_ok;

    assign w_num_pc = ADDR_W'(ir_q[15:8]);
    assign w_pc_inc = pc_q + ADDR_W'(1);
    assign w_func   = ir_q[4:3];
    assign w_op     = ir_q[2:0];

`ifdef SEQ_WATCHDOG_EN
    localparam int            WW          = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] c_WDOG_LAST = WW'(WDOG_CYC - 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          w_guarded;
    assign w_guarded   = (state_q == S_EXEC_ACT) || (state_q == S_EXEC_GAME) ||
                         ((state_q == S_WAIT) && (w_func != 2'b00));
    assign w_unused_ok = ^ir_q[7:6];
`else
    assign w_unused_ok = ^{ir_q[7:6], (WDOG_CYC > 0)};
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        fetch_wait_d = fetch_wait_q;
        act_num_d    = act_num_q;
        act_func_d   = act_func_q;
        game_num_d   = game_num_q;
        err_d        = err_q;
        tick_d       = tick_q;
        left_d       = left_q;
        act_start    = 1'b0;
        game_start   = 1'b0;

        if (stop) begin
            state_d      = S_IDLE;
            pc_d         = '0;
            err_d        = 1'b0;
            fetch_wait_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_d      = S_FETCH;
                        pc_d         = '0;
                        err_d        = 1'b0;
                        fetch_wait_d = 1'b0;
                    end
                end
                // First FETCH cycle presents the address, the second sees the word.
                S_FETCH: begin
                    if (!fetch_wait_q) begin
                        fetch_wait_d = 1'b1;
                    end else begin
                        fetch_wait_d = 1'b0;
                        ir_d         = mem_data;
                        state_d      = S_DECODE;
                        if (mem_data[2:0] == c_OP_ACT) begin
                            act_num_d  = mem_data[15:8];
                            act_func_d = mem_data[4:3];
                        end
                        if (mem_data[2:0] == c_OP_GAME) begin
                            game_num_d = mem_data[15:8];
                        end
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        c_OP_ACT: begin
                            act_start = 1'b1;
                            state_d   = S_EXEC_ACT;
                        end
                        c_OP_GAME: begin
                            game_start = 1'b1;
                            state_d    = S_EXEC_GAME;
                        end
                        c_OP_JMP: begin
                            state_d = S_FETCH;
                            case (w_func)
                                2'b00:   pc_d = w_num_pc;
                                2'b01:   pc_d = feedback_sig ? w_num_pc : w_pc_inc;
                                2'b10:   pc_d = feedback_sig ? w_pc_inc : w_num_pc;
                                default: pc_d = ir_q[5] ? (pc_q - w_num_pc) : (pc_q + w_num_pc);
                            endcase
                        end
                        c_OP_WAIT: begin
                            if (w_func == 2'b11) begin
                                state_d = S_HALT;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                                tick_d  = '0;
                                left_d  = ir_q[15:8];
                            end
                        end
                        c_OP_END: state_d = S_HALT;
                        default: begin
                            state_d = S_HALT;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                S_EXEC_ACT: begin
                    if (act_done) begin
                        pc_d    = w_pc_inc;
                        state_d = S_FETCH;
                    end
                end
                S_EXEC_GAME: begin
                    if (game_done) begin
                        pc_d    = w_pc_inc;
                        state_d = S_FETCH;
                    end
                end
                S_WAIT: begin
                    case (w_func)
                        2'b00: begin
                            if (left_q == 8'd0) begin
                                pc_d    = w_pc_inc;
                                state_d = S_FETCH;
                            end else if (tick_q == c_TICK_LAST) begin
                                tick_d = '0;
                                left_d = left_q - 8'd1;
                                if (left_q == 8'd1) begin
                                    pc_d    = w_pc_inc;
                                    state_d = S_FETCH;
                                end
                            end else begin
                                tick_d = tick_q + TW'(1);
                            end
                        end
                        2'b01, 2'b10: begin
                            if (feedback_sig == w_func[0]) begin
                                pc_d    = w_pc_inc;
                                state_d = S_FETCH;
                            end
                        end
                        default: begin
                            state_d = S_HALT;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef SEQ_WATCHDOG_EN
        // Count only while parked in a state; any transition restarts the count.
        wdog_d = '0;
        if (!stop && (state_d == state_q) && w_guarded) begin
            if (wdog_q == c_WDOG_LAST) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            fetch_wait_q <= 1'b0;
            act_num_q    <= '0;
            act_func_q   <= '0;
            game_num_q   <= '0;
            err_q        <= 1'b0;
            tick_q       <= '0;
            left_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            fetch_wait_q <= fetch_wait_d;
            act_num_q    <= act_num_d;
            act_func_q   <= act_func_d;
            game_num_q   <= game_num_d;
            err_q        <= err_d;
            tick_q       <= tick_d;
            left_q       <= left_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign act_num  = act_num_q;
    assign act_func = act_func_q;
    assign game_num = game_num_q;
    assign err      = err_q;
    assign halted   = (state_q == S_HALT);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_script_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_script_sequencer
// Directed bench for script_sequencer with a word-level timing model.
// Rev    : 1.0  initial release
// ============================================================================

module tb_script_sequencer;

    localparam int TICK = 4;
    localparam int WDOG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        feedback_sig = 1'b0;
    logic        act_done = 1'b0;
    logic        game_done = 1'b0;
    logic [15:0] mem_data;
    logic [7:0]  mem_addr, pc, act_num, game_num;
    logic [1:0]  act_func;
    logic        act_start, game_start, busy, halted, err;

    logic [15:0] script [256];
    int          checks = 0;
    int          failures = 0;
    bit          cmp_en = 1'b0;
    bit          ab = 1'b0;

    logic [7:0]  e_pc = '0, e_act_num = '0, e_game_num = '0;
    logic [1:0]  e_act_func = '0;
    logic        e_busy = 1'b0, e_halted = 1'b0, e_err = 1'b0;
    logic        e_act_start = 1'b0, e_game_start = 1'b0;

    script_sequencer #(
        .ADDR_W   (8),
        .TICK_DIV (TICK),
        .WDOG_CYC (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .feedback_sig (feedback_sig),
        .act_start    (act_start),
        .act_num      (act_num),
        .act_func     (act_func),
        .act_done     (act_done),
        .game_start   (game_start),
        .game_num     (game_num),
        .game_done    (game_done),
        .busy         (busy),
        .halted       (halted),
        .err          (err),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    // Script memory with one cycle of read latency.
    always @(posedge clk) mem_data <= script[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    task automatic adv();
        @(posedge clk);
        e_act_start  = 1'b0;
        e_game_start = 1'b0;
        if (stop) begin
            ab       = 1'b1;
            e_pc     = '0;
            e_busy   = 1'b0;
            e_halted = 1'b0;
            e_err    = 1'b0;
        end
    endtask

    task automatic halt(input logic e);
        e_busy   = 1'b0;
        e_halted = 1'b1;
        e_err    = e;
    endtask

    task automatic run_script();
        logic [15:0] w;
        int          n;
        forever begin
            adv(); if (ab) return;
            adv(); if (ab) return;
            w = script[e_pc];
            if (w[2:0] == 3'd1) begin
                e_act_start = 1'b1; e_act_num = w[15:8]; e_act_func = w[4:3];
            end
            if (w[2:0] == 3'd4) begin
                e_game_start = 1'b1; e_game_num = w[15:8];
            end
            adv(); if (ab) return;
            case (w[2:0])
                3'd1, 3'd4: begin
                    n = 0;
                    forever begin
                        adv(); if (ab) return;
                        n++;
                        if ((w[2:0] == 3'd1) ? act_done : game_done) break;
`ifdef SEQ_WATCHDOG_EN
                        if (n >= WDOG) begin halt(1'b1); return; end
`endif
                    end
                    e_pc = e_pc + 8'd1;
                end
                3'd2: begin
                    case (w[4:3])
                        2'd0: e_pc = w[15:8];
                        2'd1: e_pc = feedback_sig ? w[15:8] : e_pc + 8'd1;
                        2'd2: e_pc = feedback_sig ? e_pc + 8'd1 : w[15:8];
                        default: e_pc = w[5] ? e_pc - w[15:8] : e_pc + w[15:8];
                    endcase
                end
                3'd3: begin
                    if (w[4:3] == 2'd3) begin halt(1'b1); return; end
                    if (w[4:3] == 2'd0) begin
                        n = (w[15:8] == 8'd0) ? 1 : int'(w[15:8]) * TICK;
                        repeat (n) begin adv(); if (ab) return; end
                    end else begin
                        n = 0;
                        forever begin
                            adv(); if (ab) return;
                            n++;
                            if (feedback_sig == (w[4:3] == 2'd1)) break;
`ifdef SEQ_WATCHDOG_EN
                            if (n >= WDOG) begin halt(1'b1); return; end
`endif
                        end
                    end
                    e_pc = e_pc + 8'd1;
                end
                3'd0: begin halt(1'b0); return; end
                default: begin halt(1'b1); return; end
            endcase
        end
    endtask

    initial begin : model
        wait (rst_n === 1'b1);
        forever begin
            ab = 1'b0;
            adv();
            if (!ab && start) begin
                e_pc = '0; e_err = 1'b0; e_busy = 1'b1; e_halted = 1'b0;
                run_script();
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, e_busy);
            chk("halted", halted, e_halted);
            chk("err", err, e_err);
            chk("pc", pc, e_pc);
            chk("mem_addr", mem_addr, e_pc);
            chk("act_start", act_start, e_act_start);
            chk("game_start", game_start, e_game_start);
            chk("act_num", act_num, e_act_num);
            chk("act_func", act_func, e_act_func);
            chk("game_num", game_num, e_game_num);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_script();
        for (int i = 0; i < 256; i++) script[i] = 16'h0000;
    endtask

    initial begin
        clear_script();
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_pc", pc, 0);
        chk("rst_starts", {act_start, game_start}, 0);
        chk("rst_nums", {act_num, act_func, game_num}, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cyc(2);

        // action then end; a done during DECODE must be ignored
        script[0] = 16'h0501;
        pulse_start();
        cyc(2);
        chk("t1_act_start_c3", act_start, 1);
        chk("t1_act_num", act_num, 5);
        act_done = 1'b1;
        cyc(1);
        act_done = 1'b0;
        cyc(2);
        chk("t1_still_busy", busy, 1);
        act_done = 1'b1;
        cyc(1);
        act_done = 1'b0;
        cyc(5);
        chk("t1_halted", halted, 1);
        chk("t1_err", err, 0);
        chk("t1_pc", pc, 1);

        // unconditional jump
        clear_script();
        script[0] = 16'h0A02;
        pulse_start();
        cyc(3);
        chk("t2_pc", pc, 10);
        chk("t2_mem_addr", mem_addr, 10);
        cyc(6);

        // jump if feedback_sig == 0
        clear_script();
        script[0] = 16'h0312;
        feedback_sig = 1'b1;
        pulse_start();
        cyc(3);
        chk("t3_fb1_pc", pc, 1);
        cyc(5);
        feedback_sig = 1'b0;
        pulse_start();
        cyc(3);
        chk("t3_fb0_pc", pc, 3);
        cyc(5);

        // timed wait of 3 ticks; a start during WAIT is ignored
        clear_script();
        script[0] = 16'h0303;
        pulse_start();
        cyc(5);
        pulse_start();
        cyc(8);
        chk("t4_pc_last_wait", pc, 0);
        cyc(1);
        chk("t4_pc_after_wait", pc, 1);
        cyc(5);

        // illegal op, restart clears err; illegal wait func
        clear_script();
        script[0] = 16'h0007;
        pulse_start();
        cyc(5);
        chk("t5_halted", halted, 1);
        chk("t5_err", err, 1);
        pulse_start();
        chk("t5_restart_err", err, 0);
        chk("t5_restart_pc", pc, 0);
        cyc(5);
        script[0] = 16'h001B;
        pulse_start();
        cyc(5);
        chk("t5_wait11_err", err, 1);

        // stop during EXEC_ACT
        clear_script();
        script[0] = 16'h0502;
        script[5] = 16'h0701;
        pulse_start();
        cyc(7);
        chk("t6_pc_exec", pc, 5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t6_busy", busy, 0);
        act_done = 1'b1;
        cyc(1);
        act_done = 1'b0;
        cyc(3);
        chk("t6_idle_pc", pc, 0);
        chk("t6_idle_busy", busy, 0);

        // relative backwards jump wrapping to 255, game word, pc wrap to 0
        clear_script();
        script[0]   = 16'h0A02;
        script[10]  = 16'h0B3A;
        script[255] = 16'h0304;
        pulse_start();
        cyc(8);
        chk("t7_game_start", game_start, 1);
        chk("t7_game_num", game_num, 3);
        chk("t7_pc", pc, 255);
        game_done = 1'b1;
        cyc(1);
        game_done = 1'b0;
        cyc(1);
        game_done = 1'b1;
        cyc(1);
        game_done = 1'b0;
        chk("t7_pc_wrap", pc, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(2);

        // feedback waits and zero-length timed wait
        clear_script();
        script[0] = 16'h000B;
        script[1] = 16'h0013;
        script[2] = 16'h0003;
        feedback_sig = 1'b0;
        pulse_start();
        cyc(6);
        feedback_sig = 1'b1;
        cyc(6);
        feedback_sig = 1'b0;
        cyc(12);
        chk("t8_halted", halted, 1);
        chk("t8_pc", pc, 3);
        chk("t8_err", err, 0);

        // action whose done never arrives
        clear_script();
        script[0] = 16'h0501;
        pulse_start();
        cyc(20);
`ifdef SEQ_WATCHDOG_EN
        chk("t9_wdog_halted", halted, 1);
        chk("t9_wdog_err", err, 1);
`else
        chk("t9_still_busy", busy, 1);
        chk("t9_no_err", err, 0);
`endif
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
